// File: rtl/light_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : light_sequencer
//  Purpose  : Multi-channel LED colour sequencer. Each channel holds a CW-bit
//             colour code that cycles through the legal range 1..2^CW-2 with
//             wrap-around. A channel steps while its debounced push-button is
//             active, subject to the selected step mode. Per-channel loads
//             and illegal-code recovery are also handled here.
//  Ports    : clk         - system clock; all state updates on the rising edge
//             rst         - asynchronous reset, active low (0 = reset)
//             en          - global step enable
//             mode        - 00 step-while-held, 01 step-per-press,
//                           10 timed-step-while-held, 11 freeze
//             dir         - 0 = count up, 1 = count down
//             rate        - timed-step period minus one (mode 10)
//             button      - raw asynchronous buttons, active high
//             load        - per-channel load strobe
//             load_colour - value loaded into every channel being loaded
//             colour      - channel i code at bits [i*CW +: CW]
//             wrap        - one-cycle pulse when channel i wraps
//  Revision : 1.0 - initial release
// ============================================================================
module light_sequencer #(
  parameter int NCH       = 4,
  parameter int CW        = 3,
  parameter int PRESC_W   = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               dir,
  input  logic [PRESC_W-1:0] rate,
  input  logic [NCH-1:0]     button,
  input  logic [NCH-1:0]     load,
  input  logic [CW-1:0]      load_colour,
  output logic [NCH*CW-1:0]  colour,
  output logic [NCH-1:0]     wrap
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_PRESS  = 2'b01;
  localparam logic [1:0] MODE_TIMED  = 2'b10;

  // Debounce counter only needs to reach DB_CYCLES-1; the change is
  // accepted on the DB_CYCLES-th consecutive differing cycle.
  localparam int           DBW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  localparam logic [CW-1:0] COL_ONE = CW'(1);
  localparam logic [CW-1:0] COL_MAX = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [CW-1:0] COL_ALL = {CW{1'b1}};

  // --------------------------------------------------------------------------
  // Shared auto-step prescaler: counts 0..rate while timed mode is active.
  // Equality compare means a new rate applies from the next compare onward.
  // --------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc;
  logic               presc_run;
  logic               tick;

  assign presc_run = en && (mode == MODE_TIMED);
  assign tick      = presc_run && (presc == rate);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (!presc_run || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Illegal load values collapse to the first legal code.
  logic [CW-1:0] load_val;
  assign load_val = ((load_colour == '0) || (load_colour == COL_ALL)) ? COL_ONE : load_colour;

  // --------------------------------------------------------------------------
  // Per-channel datapath
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic           sync1;
    logic           sync2;
    logic           db;
    logic           db_prev;
    logic [DBW-1:0] db_cnt;
    logic           step;
    logic [CW-1:0]  col;
    logic           wrap_r;
    logic           illegal;

    // Synchroniser, debouncer and edge history. Runs independent of en/mode
    // so that entering step-per-press with a button held causes no step.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        db      <= 1'b0;
        db_prev <= 1'b0;
        db_cnt  <= '0;
      end else begin
        sync1   <= button[i];
        sync2   <= sync1;
        db_prev <= db;
        if (sync2 != db) begin
          if (db_cnt == DB_LAST) begin
            db     <= sync2;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end

    always_comb begin
      step = 1'b0;
      case (mode)
        MODE_HOLD:  step = en && db;
        MODE_PRESS: step = en && db && !db_prev;
        MODE_TIMED: step = en && db && tick;
        default:    step = 1'b0;
      endcase
    end

    assign illegal = (col == '0) || (col == COL_ALL);

    // Priority: load > illegal recovery > step > hold.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        col    <= COL_ONE;
        wrap_r <= 1'b0;
      end else begin
        wrap_r <= 1'b0;
        if (load[i]) begin
          col <= load_val;
        end else if (illegal) begin
          col <= COL_ONE;
        end else if (step) begin
          if (dir) begin
            if (col == COL_ONE) begin
              col    <= COL_MAX;
              wrap_r <= 1'b1;
            end else begin
              col <= col - COL_ONE;
            end
          end else begin
            if (col == COL_MAX) begin
              col    <= COL_ONE;
              wrap_r <= 1'b1;
            end else begin
              col <= col + COL_ONE;
            end
          end
        end
      end
    end

    assign colour[i*CW +: CW] = col;
    assign wrap[i]            = wrap_r;
  end

endmodule
`default_nettype wire

// File: doc/light_sequencer.md
Name: light_sequencer

Overview:
Multi-channel LED colour sequencer; next generation of the single-channel button-stepped light controller. Each channel holds a CW-bit colour code that steps through the legal range 1..2^CW-2, with wrap-around, while its debounced button is active. Adds per-channel debounce, selectable step modes, programmable auto-step rate, direction control and a parallel load. It sits between the board push-buttons and the LED driver outputs.

Parameters:
NCH, 4, number of independent channels/buttons
CW, 3, colour code width; legal codes 1..2^CW-2
PRESC_W, 16, width of auto-step prescaler/rate input
DB_CYCLES, 4, consecutive stable cycles needed to accept a button change (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  global step enable
mode  in  2  00 step-while-held, 01 step-per-press, 10 timed-step-while-held, 11 freeze
dir  in  1  0 = count up, 1 = count down
rate  in  PRESC_W  timed-step period minus one (mode 10)
button  in  NCH  raw asynchronous buttons, active-high
load  in  NCH  per-channel load strobe
load_colour  in  CW  value loaded into every channel whose load bit is 1
colour  out  NCH*CW  channel i code at bits [i*CW +: CW]
wrap  out  NCH  one-cycle pulse when channel i wraps

Behaviour:
- Reset (rst=0, async): every colour = 1, wrap = 0, sync/debounce state = 0, debounce counters = 0, prescaler = 0, edge-history = 0. Held while rst=0; leaves reset on first clk edge after rst=1.
- Input path per channel: 2-flop synchroniser -> debouncer. Debounced level db[i] changes only after the synchronised value differs from db[i] for DB_CYCLES consecutive clocks; any return to the db value clears that counter. Debounce runs regardless of en/mode.
- Step qualifier step[i], evaluated each cycle:
  - mode 00: en & db[i] (steps every clock while held).
  - mode 01: en & db[i] & ~db_prev[i] (once per debounced rising edge); db_prev updates every cycle in all modes, so switching into 01 with button held causes no step.
  - mode 10: en & db[i] & tick. Shared prescaler counts 0..rate; tick=1 in the cycle count==rate, then count returns to 0. rate=0 -> tick every cycle. Prescaler held at 0 when mode!=10 or en=0; a rate change takes effect at the next compare.
  - mode 11: never steps.
- Step arithmetic (MAX = 2^CW-2): up: c==MAX -> 1 with wrap[i]=1, else c+1. Down: c==1 -> MAX with wrap[i]=1, else c-1.
- Illegal code recovery: if a channel ever holds 0 or 2^CW-1 it is forced to 1 on the next clock (no wrap), overriding step.
- Load: load[i]=1 -> colour[i]=load_colour next clock; if load_colour is 0 or all-ones, loads 1 instead. Load overrides step and recovery; no wrap pulse. Load acts even when en=0 or mode=11.
- Priority per channel: rst > load > illegal recovery > step > hold.
- wrap is registered, high exactly one cycle per wrap event, 0 otherwise.
- Latency: raw button edge to first colour change = 2 (sync) + DB_CYCLES + 1 clocks in modes 00/01 (plus prescaler alignment in mode 10).
- Channels are fully independent except shared en, mode, dir, rate, prescaler.
- Async reset mid-step discards any pending step; no wrap pulse emitted.

Test Plan:
- Reset: rst=0 with buttons toggling -> all colour fields = 1, wrap = 0; release rst, no buttons -> values stay 1.
- Mode 00 up, CW=3, ch0 button held clean -> after 2+4+1 clocks ch0 steps 2,3,4,5,6,1; wrap[0] pulses in the 6->1 cycle only; other channels stay 1.
- Mode 01, ch1 pressed 3 separate times (each held 10 cycles) -> ch1 ends at 4, exactly one step per press; dir=1 from 1 -> 6 with wrap[1] pulse.
- Debounce: ch2 button bounces 1-0-1-0 with 2-cycle pulses, then held -> no step until 4 stable synchronised cycles, then normal stepping.
- Mode 10, rate=3, ch3 held -> ch3 steps once every 4 clocks; set en=0 -> no steps, prescaler 0; en=1 resumes with first step 4 clocks later.
- Load: load=4'b0011, load_colour=7 -> ch0, ch1 = 1; load_colour=5 with ch0 button held in mode 00 -> ch0 = 5 (load wins, no wrap), then steps to 6.
